fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage of the 16-bit pipeline; sits directly upstream of decode.
- Holds the PC and issues one instruction-memory read at a time.
- Buffers returned instructions through a 1-entry skid register so a decode stall never drops data.
- Handles redirects (branch/jump targets) by squashing in-flight and buffered fetches, and stops fetching after a HALT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, instruction driven while invalid (opcode 00001).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request valid.
- imem_addr  out  16  read address (current PC).
- imem_ready  in  1  memory accepts request this cycle (req & ready = accepted).
- imem_rvalid  in  1  read data valid, one pulse per accepted request, at least 1 cycle after accept.
- imem_rdata  in  16  read data.
- redirect  in  1  load new PC (taken branch/jump from later stage).
- redirect_pc  in  16  redirect target.
- stall  in  1  decode cannot accept this cycle.
- instr_valid  out  1  instruction/pc_plus2 valid toward decode.
- instruction  out  16  fetched instruction.
- pc_plus2  out  16  address of instruction + 2 (for JAL/JALR link and branch base).
- halted  out  1  HALT fetched and delivered; fetch stopped.
- err  out  1  sticky misaligned-redirect error.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=REQ, out_valid=0, skid_valid=0, squash=0, instruction=NOP_INSTR, pc_plus2=0, halted=0, err=0. imem_req is forced 0 while rst=0.
- State REQ:
  - imem_req=1 only if skid_valid=0; imem_addr=pc.
  - On accept: go to WAIT and record req_pc=pc.
- State WAIT:
  - imem_req=0.
  - On imem_rvalid with squash=1: discard the data, clear squash, go to REQ.
  - Otherwise the word goes to the output register if it is empty or being consumed this cycle (out_valid & ~stall); if not, it goes to the skid register. pc<=req_pc+2.
  - If imem_rdata[15:11]==5'b00000 (HALT), go to HALTED; else go to REQ.
- Output register:
  - Consumed when out_valid & ~stall.
  - On consume, refills from skid if skid_valid, else from a same-cycle rvalid, else clears out_valid.
  - instruction and pc_plus2 stay stable while out_valid & stall.
  - instruction=NOP_INSTR whenever out_valid=0.
- State HALTED:
  - No requests.
  - halted=1 once the HALT word has been consumed by decode (out_valid & ~stall with HALT opcode).
  - Only reset leaves HALTED; redirect is ignored here.
- Redirect (not HALTED): highest priority.
  - Same edge: pc<=redirect_pc, out_valid<=0, skid_valid<=0, and any same-cycle rvalid is dropped.
  - If in WAIT with no rvalid this cycle: squash<=1, stay in WAIT.
  - If in REQ: a request accepted the same cycle is treated as squashed (WAIT with squash=1); otherwise stay in REQ with the new pc.
  - If redirect_pc[0]=1: err<=1 (sticky) and go to HALTED without fetching.
- Latency: accept to instr_valid = memory latency + 1 cycle (registered output). Throughput is at most one instruction per 2 cycles with a zero-wait memory.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 wraps to 16'h0000, with no error.
- Simultaneous stall and redirect: redirect wins; the output is invalidated regardless of stall.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined: adds outputs fetch_cnt[15:0] (increments per instruction consumed by decode) and stall_cnt[15:0] (increments per cycle with out_valid & stall). Both reset to 0 and wrap at 16'hFFFF.
- When undefined: neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package: opcode constants (OP_HALT=5'b00000, OP_NOP=5'b00001), NOP_INSTR value, fetch state enum {REQ, WAIT, HALTED}, 16-bit word width constant.
- One natural sub-module: fetch_skid_buf. It holds the output register plus the skid register with valid/stall handshake, is parameterised on width, and is reused later between decode and execute.

Test Plan:
- Zero-wait memory (ready=1, rvalid 1 cycle after accept), words 0x4000@0, 0x4100@2: instr_valid pulses with instruction=0x4000/pc_plus2=2, then 0x4100/pc_plus2=4; imem_addr sequence 0,2,4.
- Stall held 5 cycles while two words return: first word stable at the output, second held in skid, no imem_req issued while skid full; after release, both delivered in order on consecutive cycles.
- Redirect to 0x0040 while in WAIT: the late rvalid word is discarded, the next request address is 0x0040, and no instr_valid appears for the squashed word.
- Redirect to 0x0041: err=1, no further imem_req, instr_valid stays 0.
- Fetch 0x0000 (HALT) at 0x0010: delivered once with pc_plus2=0x0012, halted=1 after consume; a later redirect has no effect; asserting rst=0 clears halted and restarts at RESET_PC.
- Assert rst=0 asynchronously mid-WAIT: all outputs return to reset values immediately (imem_req=0, instruction=0x0800); after release the first request address is RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage and its buffers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int              WORD_W    = 16;
    localparam logic [4:0]      OP_HALT   = 5'b00000;
    localparam logic [4:0]      OP_NOP    = 5'b00001;
    localparam logic [WORD_W-1:0] INSTR_NOP = 16'h0800;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    // True when the word carries the HALT opcode in its top five bits.
    function automatic logic is_halt(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: 5] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Output register backed by a one-entry skid register, valid/stall handshake.
// Latency: 1 cycle from i_vld to o_vld when empty; skid drains with no bubble.
// Backpressure: o_dat held stable while o_vld & i_stall; i_rdy low while skid full.
module fetch_skid_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_vld,
    input  logic [W-1:0] i_dat,
    output logic         i_rdy,
    input  logic         i_stall,
    output logic         o_vld,
    output logic [W-1:0] o_dat
);

    logic         r_out_vld;
    logic [W-1:0] r_out_dat;
    logic         r_skid_vld;
    logic [W-1:0] r_skid_dat;
    logic         w_consume;

    assign w_consume = r_out_vld & ~i_stall;
    assign i_rdy     = ~r_skid_vld;
    assign o_vld     = r_out_vld;
    assign o_dat     = r_out_dat;

    // Refill the output from skid first, then from the incoming word; park the word in skid when the output is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_skid_vld <= 1'b0;
            r_skid_dat <= '0;
        end else if (i_flush) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_consume || !r_out_vld) begin
            if (r_skid_vld) begin
                r_out_vld  <= 1'b1;
                r_out_dat  <= r_skid_dat;
                r_skid_vld <= i_vld;
                if (i_vld) begin
                    r_skid_dat <= i_dat;
                end
            end else begin
                r_out_vld <= i_vld;
                if (i_vld) begin
                    r_out_dat <= i_dat;
                end
            end
        end else if (i_vld) begin
            r_skid_vld <= 1'b1;
            r_skid_dat <= i_dat;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: holds the PC, one outstanding imem read, redirect squash, HALT stop.
// Latency: accept to instr_valid = memory latency + 1; at most one instruction per 2 cycles.
// Backpressure: stall holds the output, a second word parks in skid, no new request while skid full.
// Optional perf counters (fetch_cnt, stall_cnt) exist only when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [WORD_W-1:0] NOP_INSTR = INSTR_NOP
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] pc_plus2,
    output logic              halted,
    output logic              err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    fetch_state_e        r_state;
    fetch_state_e        nxt_state;
    logic [WORD_W-1:0]   r_pc;
    logic [WORD_W-1:0]   nxt_pc;
    logic [WORD_W-1:0]   r_req_pc;
    logic [WORD_W-1:0]   nxt_req_pc;
    logic                r_squash;
    logic                nxt_squash;
    logic                r_err;
    logic                nxt_err;
    logic                r_halted;

    logic                w_accept;
    logic                w_in_vld;
    logic                w_flush;
    logic                w_skid_rdy;
    logic                w_out_vld;
    logic [2*WORD_W-1:0] w_out_dat;
    logic [2*WORD_W-1:0] w_in_dat;
    logic                w_consume;

    // A request only goes out when the skid slot is free, so a returning word always has a home.
    assign imem_req  = rst & (r_state == ST_REQ) & w_skid_rdy;
    assign imem_addr = r_pc;
    assign w_accept  = imem_req & imem_ready;
    assign w_in_dat  = {imem_rdata, r_req_pc + 16'd2};
    assign w_consume = w_out_vld & ~stall;

    // Next-state: normal fetch sequencing, then redirect overrides everything outside HALTED.
    always_comb begin
        nxt_state  = r_state;
        nxt_pc     = r_pc;
        nxt_req_pc = r_req_pc;
        nxt_squash = r_squash;
        nxt_err    = r_err;
        w_in_vld   = 1'b0;
        w_flush    = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (w_accept) begin
                    nxt_state  = ST_WAIT;
                    nxt_req_pc = r_pc;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (r_squash) begin
                        nxt_squash = 1'b0;
                        nxt_state  = ST_REQ;
                    end else begin
                        w_in_vld  = 1'b1;
                        nxt_pc    = r_req_pc + 16'd2;
                        nxt_state = is_halt(imem_rdata) ? ST_HALTED : ST_REQ;
                    end
                end
            end
            default: begin
            end
        endcase
        if (redirect && (r_state != ST_HALTED)) begin
            w_flush  = 1'b1;
            w_in_vld = 1'b0;
            nxt_pc   = redirect_pc;
            if (r_state == ST_WAIT) begin
                // A word arriving now is dropped; otherwise the one still in flight must be.
                nxt_state  = imem_rvalid ? ST_REQ : ST_WAIT;
                nxt_squash = ~imem_rvalid;
            end else begin
                nxt_state  = w_accept ? ST_WAIT : ST_REQ;
                nxt_squash = w_accept;
            end
            if (redirect_pc[0]) begin
                nxt_err   = 1'b1;
                nxt_state = ST_HALTED;
            end
        end
    end

    // State, PC and sticky flags; halted sets once decode takes the HALT word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_REQ;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_squash <= 1'b0;
            r_err    <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= nxt_state;
            r_pc     <= nxt_pc;
            r_req_pc <= nxt_req_pc;
            r_squash <= nxt_squash;
            r_err    <= nxt_err;
            if (w_consume && is_halt(w_out_dat[2*WORD_W-1 -: WORD_W])) begin
                r_halted <= 1'b1;
            end
        end
    end

    fetch_skid_buf #(
        .W (2*WORD_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_vld   (w_in_vld),
        .i_dat   (w_in_dat),
        .i_rdy   (w_skid_rdy),
        .i_stall (stall),
        .o_vld   (w_out_vld),
        .o_dat   (w_out_dat)
    );

    assign instr_valid = w_out_vld;
    assign instruction = w_out_vld ? w_out_dat[2*WORD_W-1 -: WORD_W] : NOP_INSTR;
    assign pc_plus2    = w_out_dat[WORD_W-1:0];
    assign halted      = r_halted;
    assign err         = r_err;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;

    // Free-running wrap-around counters of delivered instructions and stalled-output cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt <= 16'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            if (w_consume) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (w_out_vld && stall) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable memory and a stream scoreboard.
// Latency: n/a.
// Backpressure: stall driven per scenario.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [15:0] pc_plus2;
    logic        halted;
    logic        err;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0800)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .pc_plus2    (pc_plus2),
        .halted      (halted),
        .err         (err)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int mem_lat = 1;
    int mem_cnt = 0;
    logic [15:0] mem_addr_q = 16'h0000;
    logic [15:0] mem [int];

    logic [15:0] exp_addr [$];
    logic [31:0] exp_del [$];
    logic [31:0] got_q [$];
    int          cons_t [$];
    logic        chk_en = 1'b0;
    int          acc_total = 0;
    int          first_acc = -1;
    int          first_vld = -1;
    logic        p_hold = 1'b0;
    logic [31:0] p_dat = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 16'h0800;
    endfunction

    // Program-order model: sequential fetch from start until a HALT word is delivered.
    task automatic build_expect(input logic [15:0] start);
        logic [15:0] pc;
        logic [15:0] w;
        pc = start;
        for (int i = 0; i < 32; i++) begin
            exp_addr.push_back(pc);
            w = mem_rd(pc);
            exp_del.push_back({w, pc + 16'd2});
            if (w[15:11] == 5'b00000) break;
            pc = pc + 16'd2;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: one response mem_lat cycles after each accepted request; forgets everything in reset.
    always @(negedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        if (!rst) begin
            mem_cnt = 0;
        end else begin
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_rd(mem_addr_q);
                end
            end
            if (imem_req && imem_ready) begin
                mem_addr_q = imem_addr;
                mem_cnt    = mem_lat;
            end
        end
    end

    // Compare process: request addresses, delivered stream, hold-under-stall, NOP when invalid.
    always @(negedge clk) begin
        #2;
        if (rst && chk_en) begin
            if (imem_req && imem_ready) begin
                acc_total++;
                if (first_acc < 0) first_acc = cyc;
                if (exp_addr.size() == 0) check("extra_req", {31'h0, imem_req}, 32'h0);
                else check("imem_addr", {16'h0, imem_addr}, {16'h0, exp_addr.pop_front()});
            end
            if (!instr_valid) check("nop_when_invalid", {16'h0, instruction}, 32'h0000_0800);
            else if (first_vld < 0) first_vld = cyc;
            if (p_hold) begin
                check("hold_vld", {31'h0, instr_valid}, 32'h1);
                check("hold_dat", {instruction, pc_plus2}, p_dat);
            end
            if (instr_valid && !stall) begin
                got_q.push_back({instruction, pc_plus2});
                cons_t.push_back(cyc);
                if (exp_del.size() == 0) check("extra_instr", {31'h0, instr_valid}, 32'h0);
                else check("deliver", {instruction, pc_plus2}, exp_del.pop_front());
            end
            p_hold = instr_valid && stall && !redirect;
            p_dat  = {instruction, pc_plus2};
        end else begin
            p_hold = 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        chk_en = 1'b0;
        rst = 1'b0;
        redirect = 1'b0;
        stall = 1'b0;
        imem_ready = 1'b1;
        exp_addr.delete();
        exp_del.delete();
        repeat (2) @(negedge clk);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_vld", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", {16'h0, instruction}, 32'h0000_0800);
        check("rst_pcp2", {16'h0, pc_plus2}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
    endtask

    task automatic release_rst();
        got_q.delete();
        cons_t.delete();
        first_acc = -1;
        first_vld = -1;
        chk_en = 1'b1;
        rst = 1'b1;
    endtask

    task automatic wait_accept();
        int k;
        for (k = 0; k < 50; k++) begin
            #1;
            if (imem_req && imem_ready) break;
            @(negedge clk);
        end
        if (k == 50) check("accept_timeout", {31'h0, imem_req}, 32'h1);
    endtask

    task automatic wait_halted();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (halted) break;
        end
        check("halted_set", {31'h0, halted}, 32'h1);
    endtask

    task automatic redirect_pulse(input logic [15:0] target);
        redirect = 1'b1;
        redirect_pc = target;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic queues_drained(input string name);
        check({name, "_addr_left"}, exp_addr.size(), 32'h0);
        check({name, "_del_left"}, exp_del.size(), 32'h0);
    endtask

    initial begin
        mem[16'h0000] = 16'h4000;
        mem[16'h0002] = 16'h4100;
        mem[16'h0004] = 16'h4200;
        mem[16'h0006] = 16'h0000;
        mem[16'h0010] = 16'h0000;
        mem[16'h0040] = 16'h4400;
        mem[16'h0042] = 16'h0000;

        // Zero-wait memory, straight-line run to HALT, then a redirect that must be ignored.
        mem_lat = 1;
        do_reset();
        build_expect(16'h0000);
        release_rst();
        wait_halted();
        repeat (3) @(negedge clk);
        queues_drained("t1");
        check("t1_first", got_q[0], {16'h4000, 16'h0002});
        check("t1_second", got_q[1], {16'h4100, 16'h0004});
        check("t1_latency", first_vld - first_acc, 32'd2);
        redirect_pulse(16'h0100);
        repeat (5) @(negedge clk);
        check("t1_halt_sticky", {31'h0, halted}, 32'h1);
        check("t1_no_err", {31'h0, err}, 32'h0);

        // Long stall: output held, second word parked in skid, requests stop, then back-to-back drain.
        begin
            int n0;
            do_reset();
            stall = 1'b1;
            build_expect(16'h0000);
            n0 = acc_total;
            release_rst();
            repeat (8) @(negedge clk);
            check("t2_acc_in_stall", acc_total - n0, 32'd2);
            check("t2_vld_in_stall", {31'h0, instr_valid}, 32'h1);
            check("t2_out_in_stall", {16'h0, instruction}, 32'h0000_4000);
            stall = 1'b0;
            wait_halted();
            repeat (3) @(negedge clk);
            queues_drained("t2");
            check("t2_back_to_back", cons_t[1] - cons_t[0], 32'd1);
            check("t2_second", got_q[1], {16'h4100, 16'h0004});
        end

        // Redirect while waiting: late word squashed, fetch resumes at 0x0040.
        mem_lat = 3;
        do_reset();
        exp_addr.push_back(16'h0000);
        build_expect(16'h0040);
        release_rst();
        wait_accept();
        @(negedge clk);
        redirect_pulse(16'h0040);
        wait_halted();
        repeat (3) @(negedge clk);
        queues_drained("t3");
        check("t3_first", got_q[0], {16'h4400, 16'h0042});

        // Misaligned redirect: sticky err, no more requests, nothing delivered.
        do_reset();
        exp_addr.push_back(16'h0000);
        release_rst();
        wait_accept();
        @(negedge clk);
        redirect_pulse(16'h0041);
        repeat (12) @(negedge clk);
        check("t4_err", {31'h0, err}, 32'h1);
        check("t4_not_halted", {31'h0, halted}, 32'h0);
        check("t4_delivered", got_q.size(), 32'h0);
        queues_drained("t4");

        // HALT at 0x0010 reached by redirect; redirect afterwards ignored; reset restarts at 0.
        do_reset();
        exp_addr.push_back(16'h0000);
        build_expect(16'h0010);
        release_rst();
        wait_accept();
        @(negedge clk);
        redirect_pulse(16'h0010);
        wait_halted();
        repeat (3) @(negedge clk);
        queues_drained("t5");
        check("t5_halt_word", got_q[0], {16'h0000, 16'h0012});
        check("t5_once", got_q.size(), 32'h1);
        redirect_pulse(16'h0020);
        repeat (6) @(negedge clk);
        check("t5_halt_sticky", {31'h0, halted}, 32'h1);
        #3;
        chk_en = 1'b0;
        rst = 1'b0;
        #1;
        check("t5_rst_clears_halt", {31'h0, halted}, 32'h0);
        repeat (2) @(negedge clk);
        mem_lat = 1;
        build_expect(16'h0000);
        release_rst();
        wait_halted();
        repeat (3) @(negedge clk);
        queues_drained("t5r");
        check("t5_restart", got_q[0], {16'h4000, 16'h0002});

        // Asynchronous reset mid-WAIT with a held word on the output.
        begin
            int k;
            mem_lat = 3;
            do_reset();
            stall = 1'b1;
            build_expect(16'h0000);
            release_rst();
            for (k = 0; k < 50; k++) begin
                @(negedge clk);
                if (instr_valid) break;
            end
            check("t6_vld_before_rst", {31'h0, instr_valid}, 32'h1);
            wait_accept();
            @(negedge clk);
            #3;
            chk_en = 1'b0;
            rst = 1'b0;
            #1;
            check("t6_async_req", {31'h0, imem_req}, 32'h0);
            check("t6_async_vld", {31'h0, instr_valid}, 32'h0);
            check("t6_async_instr", {16'h0, instruction}, 32'h0000_0800);
            check("t6_async_pcp2", {16'h0, pc_plus2}, 32'h0);
            stall = 1'b0;
            exp_addr.delete();
            exp_del.delete();
            repeat (2) @(negedge clk);
            build_expect(16'h0000);
            release_rst();
            wait_halted();
            repeat (3) @(negedge clk);
            queues_drained("t6");
            check("t6_restart", got_q[0], {16'h4000, 16'h0002});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule
